// File: rtl/dsp_vec_alu_pkg.sv
// rtl/dsp_vec_alu_pkg.sv - dsp_pkg: op/state enums, Q16.16 constants, result slice helper
// DSP_VEC_SAT_EN selects clamping in dsp_slice instead of two's-complement wrap.
package dsp_pkg;
   localparam int DSP_LANES     = 8;
   localparam int DSP_DATA_W    = 32;
   localparam int DSP_FRAC_BITS = 16;
   localparam int DSP_LANE_W    = $clog2(DSP_LANES);
   localparam int DSP_ACC_W     = 2*DSP_DATA_W + 3;
   localparam int DSP_HI        = DSP_FRAC_BITS + DSP_DATA_W - 1;

   typedef enum logic [1:0] {OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2, OP_DOT = 2'd3} dsp_op_e;
   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, WB = 2'd2} dsp_state_e;

   typedef logic [DSP_DATA_W-1:0]                 dsp_elem_t;
   typedef logic [DSP_LANES-1:0][DSP_DATA_W-1:0]  dsp_vec_t;
   typedef logic [DSP_ACC_W-1:0]                  dsp_wide_t;

   // Input carries FRAC_BITS extra fraction bits; out-of-range upper bits clamp when saturating.
   function automatic dsp_elem_t dsp_slice(input dsp_wide_t v);
`ifdef DSP_VEC_SAT_EN
      if (!v[DSP_ACC_W-1] && (|v[DSP_ACC_W-1:DSP_HI]))
         return {1'b0, {(DSP_DATA_W-1){1'b1}}};
      if (v[DSP_ACC_W-1] && !(&v[DSP_ACC_W-1:DSP_HI]))
         return {1'b1, {(DSP_DATA_W-1){1'b0}}};
`endif
      return v[DSP_HI:DSP_FRAC_BITS];
   endfunction
endpackage

// File: rtl/dsp_vec_alu_if.sv
// rtl/dsp_vec_alu_if.sv - operand read / result write-back bundle between memory side and the ALU
interface dsp_vec_alu_if;
   import dsp_pkg::*;

   logic       start;
   dsp_op_e    op;
   logic [1:0] rd;
   dsp_vec_t   busA;
   dsp_vec_t   busB;
   logic       busy;
   logic       done;
   logic       MemWrite;
   logic [1:0] RW;
   dsp_vec_t   busW;

   modport master (output start, op, rd, busA, busB,
                   input  busy, done, MemWrite, RW, busW);
   modport slave  (input  start, op, rd, busA, busB,
                   output busy, done, MemWrite, RW, busW);
endinterface

// File: rtl/dsp_lane_alu.sv
// rtl/dsp_lane_alu.sv - combinational single-lane add/sub/mul with Q16.16 slice
// Saturation under DSP_VEC_SAT_EN is applied inside dsp_slice.
module dsp_lane_alu
   import dsp_pkg::*;
(
   input  dsp_op_e                  op_i,
   input  dsp_elem_t                a_i,
   input  dsp_elem_t                b_i,
   output dsp_elem_t                res_o,
   output logic [2*DSP_DATA_W-1:0]  prod_o
);
   logic [DSP_DATA_W:0]     sum;
   logic [2*DSP_DATA_W-1:0] prod;
   dsp_wide_t               wide;

   always_comb begin
      prod = {{DSP_DATA_W{a_i[DSP_DATA_W-1]}}, a_i} * {{DSP_DATA_W{b_i[DSP_DATA_W-1]}}, b_i};
      if (op_i == OP_SUB)
         sum = {a_i[DSP_DATA_W-1], a_i} - {b_i[DSP_DATA_W-1], b_i};
      else
         sum = {a_i[DSP_DATA_W-1], a_i} + {b_i[DSP_DATA_W-1], b_i};
      // add/sub results are lifted to the same scaled format as products so one slice serves both
      case (op_i)
         OP_ADD, OP_SUB:
            wide = {{(DSP_ACC_W-DSP_DATA_W-1-DSP_FRAC_BITS){sum[DSP_DATA_W]}}, sum, {DSP_FRAC_BITS{1'b0}}};
         default:
            wide = {{(DSP_ACC_W-2*DSP_DATA_W){prod[2*DSP_DATA_W-1]}}, prod};
      endcase
      res_o = dsp_slice(wide);
   end

   assign prod_o = prod;
endmodule

// File: rtl/dsp_vec_alu.sv
// rtl/dsp_vec_alu.sv - sequential 8-lane Q16.16 vector ALU with single-cycle write-back
// Optional DSP_VEC_SAT_EN build macro saturates results instead of wrapping.
module dsp_vec_alu
   import dsp_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   dsp_vec_alu_if.slave   bus
);
   dsp_state_e              state_q;
   dsp_op_e                 op_q;
   logic [1:0]              rd_q;
   logic [1:0]              rw_q;
   dsp_vec_t                a_q;
   dsp_vec_t                b_q;
   dsp_vec_t                busw_q;
   logic [DSP_LANE_W-1:0]   lane_q;
   dsp_wide_t               acc_q;
   dsp_wide_t               acc_d;
   logic                    busy_q;
   logic                    done_q;
   logic                    mw_q;
   dsp_elem_t               lane_res;
   logic [2*DSP_DATA_W-1:0] lane_prod;
   dsp_vec_t                dot_vec;

   dsp_lane_alu u_lane (
      .op_i   (op_q),
      .a_i    (a_q[lane_q]),
      .b_i    (b_q[lane_q]),
      .res_o  (lane_res),
      .prod_o (lane_prod)
   );

   always_comb begin
      acc_d      = acc_q + {{(DSP_ACC_W-2*DSP_DATA_W){lane_prod[2*DSP_DATA_W-1]}}, lane_prod};
      dot_vec    = '0;
      dot_vec[0] = dsp_slice(acc_d);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         op_q    <= OP_ADD;
         rd_q    <= '0;
         rw_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         busw_q  <= '0;
         lane_q  <= '0;
         acc_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         mw_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         mw_q   <= 1'b0;
         case (state_q)
            IDLE: if (bus.start) begin
               op_q    <= bus.op;
               rd_q    <= bus.rd;
               a_q     <= bus.busA;
               b_q     <= bus.busB;
               acc_q   <= '0;
               lane_q  <= '0;
               busy_q  <= 1'b1;
               state_q <= EXEC;
            end
            EXEC: begin
               if (op_q == OP_DOT)
                  acc_q <= acc_d;
               else
                  busw_q[lane_q] <= lane_res;
               lane_q <= lane_q + DSP_LANE_W'(1);
               // final lane folds straight into the write-back registers
               if (lane_q == DSP_LANE_W'(DSP_LANES-1)) begin
                  state_q <= WB;
                  mw_q    <= 1'b1;
                  done_q  <= 1'b1;
                  rw_q    <= rd_q;
                  if (op_q == OP_DOT)
                     busw_q <= dot_vec;
               end
            end
            WB: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.MemWrite = mw_q;
   assign bus.RW       = rw_q;
   assign bus.busW     = busw_q;
endmodule

// File: tb/tb_dsp_vec_alu.sv
// tb/tb_dsp_vec_alu.sv - table, random and corner-sequence bench for dsp_vec_alu (honours DSP_VEC_SAT_EN)
module tb_dsp_vec_alu;
   import dsp_pkg::*;

   typedef logic [DSP_LANES-1:0][DSP_DATA_W-1:0] vec_t;
   typedef struct {
      logic [1:0] op;
      logic [1:0] rd;
      vec_t       a;
      vec_t       b;
      vec_t       exp;
      string      name;
   } rec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   errors = 0;
   int   checks = 0;
   rec_t tbl[$];
   vec_t mem_a, mem_b, add_exp;

   dsp_vec_alu_if bus();
   dsp_vec_alu dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h", nm, got, exp);
      end
   endtask

   function automatic logic [31:0] fit(input logic signed [95:0] v);
`ifdef DSP_VEC_SAT_EN
      if (v > 96'sh7FFFFFFF) return 32'h7FFFFFFF;
      if (v < -96'sh80000000) return 32'h80000000;
`endif
      return v[31:0];
   endfunction

   // Reference: exact integer arithmetic on raw Q16.16 values, floor on rescale.
   function automatic vec_t model(input logic [1:0] op, input vec_t a, input vec_t b);
      vec_t r;
      logic signed [95:0] av, bv, dot;
      r   = '0;
      dot = '0;
      for (int i = 0; i < DSP_LANES; i++) begin
         av = $signed(a[i]);
         bv = $signed(b[i]);
         case (op)
            2'd0:    r[i] = fit(av + bv);
            2'd1:    r[i] = fit(av - bv);
            2'd2:    r[i] = fit((av * bv) >>> DSP_FRAC_BITS);
            default: dot  = dot + av * bv;
         endcase
      end
      if (op == 2'd3) r[0] = fit(dot >>> DSP_FRAC_BITS);
      return r;
   endfunction

   function automatic vec_t rnd_vec();
      vec_t v;
      logic [31:0] t;
      for (int i = 0; i < DSP_LANES; i++) begin
         case ($urandom_range(0, 2))
            0: t = $urandom();
            1: begin
               t = $urandom_range(0, 32'h000FFFFF);
               if ($urandom_range(0, 1) == 1) t = -t;
            end
            default: case ($urandom_range(0, 2))
               0: t = 32'h7FFFFFFF;
               1: t = 32'h80000000;
               default: t = 32'h7FFF0000;
            endcase
         endcase
         v[i] = t;
      end
      return v;
   endfunction

   // Called at a negedge while the DUT is idle; start is sampled at the next posedge (cycle T).
   task automatic run_op(input logic [1:0] op, input logic [1:0] rd, input vec_t a, input vec_t b,
                         input vec_t exp, input string nm);
      int n;
      bit seen, busy_ok;
      bus.start = 1'b1;
      bus.op    = dsp_op_e'(op);
      bus.rd    = rd;
      bus.busA  = a;
      bus.busB  = b;
      @(negedge clk);
      bus.start = 1'b0;
      bus.busA  = rnd_vec();
      bus.busB  = rnd_vec();
      n = 1; seen = 0; busy_ok = 1;
      while (!seen && n <= 20) begin
         if (bus.MemWrite) seen = 1;
         else begin
            if (!bus.busy || bus.done) busy_ok = 0;
            @(negedge clk);
            n++;
         end
      end
      chk({nm, " memwrite_seen"}, seen, 1'b1);
      if (seen) begin
         chk({nm, " latency"}, n, DSP_LANES + 1);
         chk({nm, " done"}, bus.done, 1'b1);
         chk({nm, " busy_wb"}, bus.busy, 1'b1);
         chk({nm, " RW"}, bus.RW, rd);
         chk({nm, " busW"}, bus.busW, exp);
      end
      chk({nm, " busy_exec"}, busy_ok, 1'b1);
      @(negedge clk);
      chk({nm, " busy_after"}, bus.busy, 1'b0);
      chk({nm, " memwrite_after"}, bus.MemWrite, 1'b0);
      chk({nm, " busW_stable"}, bus.busW, exp);
   endtask

   initial begin
      rec_t r;
      vec_t a, b;
      logic [1:0] op;
      int wr_cyc[$];
      int writes;

      bus.start = 1'b0;
      bus.op    = OP_ADD;
      bus.rd    = 2'd0;
      bus.busA  = '0;
      bus.busB  = '0;

      for (int i = 0; i < DSP_LANES; i++) begin
         mem_a[i]   = 32'((2*i + 1) << 16);
         mem_b[i]   = 32'((2*i + 2) << 16);
         add_exp[i] = 32'((4*i + 3) << 16);
      end
      r = '{op: 2'd0, rd: 2'd2, a: mem_a, b: mem_b, exp: add_exp, name: "add_image"};
      tbl.push_back(r);
      r.op = 2'd2; r.rd = 2'd3; r.name = "mul_image";
      for (int i = 0; i < DSP_LANES; i++) r.exp[i] = 32'(((2*i + 1) * (2*i + 2)) << 16);
      tbl.push_back(r);
      r.op = 2'd3; r.rd = 2'd1; r.name = "dot_image";
      r.exp = '0; r.exp[0] = 32'h02E80000;
      tbl.push_back(r);
      r.op = 2'd2; r.rd = 2'd0; r.name = "mul_neg_half";
      for (int i = 0; i < DSP_LANES; i++) begin
         r.a[i] = 32'hFFFF8000; r.b[i] = 32'h00030000; r.exp[i] = 32'hFFFE8000;
      end
      tbl.push_back(r);
      r.a = '0; r.b = '0; r.exp = '0;
      r.op = 2'd0; r.rd = 2'd1; r.name = "add_ovf";
      r.a[0] = 32'h7FFF0000; r.b[0] = 32'h00020000;
`ifdef DSP_VEC_SAT_EN
      r.exp[0] = 32'h7FFFFFFF;
`else
      r.exp[0] = 32'h80010000;
`endif
      tbl.push_back(r);
      r.op = 2'd1; r.rd = 2'd2; r.name = "sub_ovf";
      r.a[0] = 32'h80000000; r.b[0] = 32'h00010000;
`ifdef DSP_VEC_SAT_EN
      r.exp[0] = 32'h80000000;
`else
      r.exp[0] = 32'h7FFF0000;
`endif
      tbl.push_back(r);
      r.op = 2'd2; r.rd = 2'd3; r.name = "mul_ovf";
      r.a[0] = 32'h7FFF0000; r.b[0] = 32'h00020000;
`ifdef DSP_VEC_SAT_EN
      r.exp[0] = 32'h7FFFFFFF;
`else
      r.exp[0] = 32'hFFFE0000;
`endif
      tbl.push_back(r);

      repeat (2) @(negedge clk);
      chk("reset busy", bus.busy, 1'b0);
      chk("reset done", bus.done, 1'b0);
      chk("reset MemWrite", bus.MemWrite, 1'b0);
      chk("reset RW", bus.RW, 2'd0);
      chk("reset busW", bus.busW, '0);
      reset = 1'b0;
      @(negedge clk);

      foreach (tbl[k]) run_op(tbl[k].op, tbl[k].rd, tbl[k].a, tbl[k].b, tbl[k].exp, tbl[k].name);

      for (int k = 0; k < 12; k++) begin
         op = 2'($urandom_range(0, 3));
         a  = rnd_vec();
         b  = rnd_vec();
         run_op(op, 2'($urandom_range(0, 3)), a, b, model(op, a, b), $sformatf("rand%0d_op%0d", k, op));
      end

      // start pulses at T+3 (EXEC) and T+9 (WB) are ignored; the one at T+10 launches a new op
      bus.start = 1'b1; bus.op = OP_ADD; bus.rd = 2'd2; bus.busA = mem_a; bus.busB = mem_b;
      @(negedge clk);
      bus.start = 1'b0;
      for (int n = 1; n <= 21; n++) begin
         if (bus.MemWrite) wr_cyc.push_back(n);
         if (n == 10) chk("ignore_start_wb busy", bus.busy, 1'b0);
         if (n == 11) chk("accept_start_t10 busy", bus.busy, 1'b1);
         bus.start = (n == 3 || n == 9 || n == 10);
         @(negedge clk);
      end
      bus.start = 1'b0;
      chk("ignore_start writes", wr_cyc.size(), 2);
      if (wr_cyc.size() == 2) begin
         chk("ignore_start first_write", wr_cyc[0], 9);
         chk("ignore_start second_write", wr_cyc[1], 19);
      end
      chk("ignore_start busW", bus.busW, add_exp);

      // reset asserted at T+4 mid-EXEC
      bus.start = 1'b1; bus.op = OP_SUB; bus.rd = 2'd1; bus.busA = mem_b; bus.busB = mem_a;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      chk("midreset busy_before", bus.busy, 1'b1);
      reset = 1'b1;
      #1;
      chk("midreset busy", bus.busy, 1'b0);
      chk("midreset MemWrite", bus.MemWrite, 1'b0);
      chk("midreset busW", bus.busW, '0);
      chk("midreset RW", bus.RW, 2'd0);
      @(negedge clk);
      reset = 1'b0;
      writes = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.MemWrite) writes++;
      end
      chk("midreset no_write", writes, 0);
      run_op(2'd0, 2'd2, mem_a, mem_b, add_exp, "after_reset_add");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
